// File: rtl/axis_bus_arbiter_if.sv
// Handshake and bus-select bundle between the FIFO channels, the AXIS bus mux and the arbiter.
// slave is the arbiter's view; master is the FIFO/mux side.
interface axis_bus_arbiter_if #(
    parameter int NUM_IN = 6
);
    logic [NUM_IN-1:0] in_tvalid;
    logic [NUM_IN-1:0] in_tlast;
    logic [NUM_IN-1:0] in_tready;
    logic              axis_out_tready;
    logic [7:0]        bus_sel;

    modport slave (
        input  in_tvalid,
        input  in_tlast,
        input  axis_out_tready,
        output in_tready,
        output bus_sel
    );

    modport master (
        output in_tvalid,
        output in_tlast,
        output axis_out_tready,
        input  in_tready,
        input  bus_sel
    );
endinterface

// File: rtl/axis_bus_arbiter.sv
// Round-robin packet arbiter: grants one FIFO channel at a time onto a shared AXIS bus
// and holds the grant until the packet's tlast beat, reporting a saturating beat count.
module axis_bus_arbiter #(
    parameter int         NUM_IN          = 6,
    parameter logic [7:0] CHOOSE_BASE     = 8'd128,
    parameter logic [7:0] NON_FIFO_CHOOSE = 8'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arb_en,
    axis_bus_arbiter_if.slave        bus,
    output logic [2:0]               grant_id,
    output logic                     busy,
    output logic                     pkt_done,
    output logic [15:0]              pkt_beats
);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        bus_sel_q, bus_sel_d;
    logic [2:0]        grant_id_q, grant_id_d;
    logic [2:0]        last_grant_q, last_grant_d;
    logic [15:0]       beat_cnt_q, beat_cnt_d;
    logic [15:0]       pkt_beats_q, pkt_beats_d;
    logic              pkt_done_q, pkt_done_d;
    logic [1:0]        sync_q, sync_d;

    logic [NUM_IN-1:0] grant_oh;
    logic              gnt_valid;
    logic              gnt_last;
    logic              beat;
    logic              arb_ready;
    logic [2:0]        pick;
    logic [15:0]       cnt_inc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [2:0] rr_pick(input logic [NUM_IN-1:0] req, input logic [2:0] last);
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = (int'(last) + 1 + k) % NUM_IN;
            if (!found && req[idx]) begin
                sel   = 3'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            grant_oh[i] = (grant_id_q == 3'(i));
        end
    end

    assign gnt_valid = |(bus.in_tvalid & grant_oh);
    assign gnt_last  = |(bus.in_tlast & grant_oh);
    assign beat      = (state_q == XFER) && gnt_valid && bus.axis_out_tready;
    // Grants wait for the reset-release synchronizer so no grant lands on the first edge.
    assign arb_ready = sync_q[1];
    assign pick      = rr_pick(bus.in_tvalid, last_grant_q);
    assign cnt_inc   = sat_inc(beat_cnt_q);
    assign sync_d    = {sync_q[0], 1'b1};

    always_comb begin
        state_d      = state_q;
        bus_sel_d    = bus_sel_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_beats_d  = pkt_beats_q;
        pkt_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_en && arb_ready && (|bus.in_tvalid)) begin
                    state_d    = XFER;
                    bus_sel_d  = CHOOSE_BASE + 8'(pick);
                    grant_id_d = pick;
                end
            end
            XFER: begin
                if (beat) begin
                    beat_cnt_d = cnt_inc;
                    if (gnt_last) begin
                        state_d      = IDLE;
                        bus_sel_d    = NON_FIFO_CHOOSE;
                        grant_id_d   = '0;
                        last_grant_d = grant_id_q;
                        pkt_beats_d  = cnt_inc;
                        pkt_done_d   = 1'b1;
                        beat_cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bus_sel_q    <= NON_FIFO_CHOOSE;
            grant_id_q   <= '0;
            last_grant_q <= 3'(NUM_IN - 1);
            beat_cnt_q   <= '0;
            pkt_beats_q  <= '0;
            pkt_done_q   <= 1'b0;
            sync_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            bus_sel_q    <= bus_sel_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_beats_q  <= pkt_beats_d;
            pkt_done_q   <= pkt_done_d;
            sync_q       <= sync_d;
        end
    end

    // tready is a pure combinational pass-through so the FIFO sees downstream stalls the same cycle.
    assign bus.in_tready = ((state_q == XFER) && bus.axis_out_tready) ? grant_oh : '0;
    assign bus.bus_sel   = bus_sel_q;
    assign grant_id      = grant_id_q;
    assign busy          = (state_q == XFER);
    assign pkt_done      = pkt_done_q;
    assign pkt_beats     = pkt_beats_q;

endmodule
